// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with rotating priority pointer and bounded tenure.
// The one-hot grant is a decode of the registered grant_id gated by busy.

// 3-to-8 line decoder with active-high enable.
module line_dec_3to8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] dout
);

  // One-hot decode of sel; all zero when disabled.
  always_comb begin
    dout = '0;
    if (en) begin
      dout[sel] = 1'b1;
    end
  end

endmodule

module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       busy
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [ID_W-1:0]  scan_idx;
  logic             pick_found;
  logic [ID_W-1:0]  pick_id;
  logic             others_pending;

  // Grant lines come straight from registered state, so req has no path to grant.
  line_dec_3to8 u_dec (
    .sel  (grant_id_q),
    .en   (busy_q),
    .dout (grant)
  );

  assign grant_id = grant_id_q;
  assign busy     = busy_q;

  // Another requester is waiting besides the current holder.
  assign others_pending = |(req & ~grant);

  // First set request scanning upward from ptr with wrap-around.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = ptr_q;
    scan_idx   = ptr_q;
    for (int i = 0; i < int'(N_REQ); i++) begin
      scan_idx = ptr_q + ID_W'(i);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

  // Next-state: arbitrate in IDLE; release, preempt or hold in GRANT.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (pick_found) begin
          state_d    = GRANT;
          grant_id_d = pick_id;
          busy_d     = 1'b1;
          hold_cnt_d = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!req[grant_id_q] || ((hold_cnt_q >= MAX_HOLD_C) && others_pending)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ptr_d   = grant_id_q + ID_W'(1);
        end else if (hold_cnt_q < MAX_HOLD_C) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-way round-robin arbiter that shares a single resource among eight requesters and drives a one-hot grant. The grant vector is produced by the team's 3-to-8 line decoder, enabled by the arbiter's `busy` flag and driven from a registered `grant_id`. The arbiter enforces fairness with a rotating priority pointer and a bounded tenure counter. It sits between the requesting units and the shared datapath and is the only source of that datapath's select lines.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while another requester is pending; legal range 1..15.

- `clock`  input  1  rising-edge clock for all state.
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  8  request vector; bit i is requester i; level-sensitive, held until served.
- `grant`  output  8  one-hot grant, equal to decode(`grant_id`) gated by `busy`; all zero when idle.
- `grant_id`  output  3  index of the current or last granted requester.
- `busy`  output  1  high while a grant is active.

## Operation
- Internal registers:
  - `state` ∈ {IDLE, GRANT}.
  - `ptr[2:0]`: highest-priority index for the next arbitration.
  - `hold_cnt[3:0]`: counts grant cycles.
- **Reset** (synchronous): `state`=IDLE, `ptr`=0, `grant_id`=0, `busy`=0, `hold_cnt`=0, therefore `grant`=8'h00. Reset wins over every other event, including a reset asserted mid-grant.
- **IDLE:**
  - If `req`==0, stay in IDLE with `busy`=0.
  - Otherwise select the first set bit scanning `ptr`, `ptr`+1, … mod 8, with wrap-around from 7 to 0.
  - Load `grant_id` with that index, set `busy`=1 and `hold_cnt`=1, then go to GRANT.
- **GRANT**, evaluated in this priority order:
  1. **Release.** If `req[grant_id]`==0: go to IDLE, `busy`=0, `ptr`=`grant_id`+1 mod 8.
  2. **Preempt.** If `hold_cnt`≥`MAX_HOLD` and (`req` with bit `grant_id` masked) ≠ 0: go to IDLE, `busy`=0, `ptr`=`grant_id`+1 mod 8.
  3. **Hold.** Otherwise stay in GRANT; `hold_cnt` increments, saturating at `MAX_HOLD`.
- **No contention:** a lone requester keeps the grant indefinitely with no gap. The counter saturates and preempts as soon as any other request appears.
- `grant_id` keeps its last value while in IDLE. It is meaningful to consumers only when `busy`=1.
- Invariants that must always hold:
  - `grant` has at most one bit set.
  - `grant`≠0 if and only if `busy`=1.
  - The granted requester had its `req` bit set on the cycle the grant was issued.
- **Fairness:** with all eight requesting continuously, each requester is served once every 8×(`MAX_HOLD`+1) cycles.

## Timing
- All outputs change only on a rising `clock` edge. `grant` is a pure decode of registered `grant_id`/`busy`, so it has no combinational path from `req`.
- **Request to grant:** `req` sampled at edge k while in IDLE gives `grant` valid after edge k.
- **Release/preempt:** the condition sampled at edge k drops `grant` to 0 after edge k. The earliest next grant appears after edge k+1, so there is exactly one dead cycle between any two grants.
- **Tenure:** a contended grant lasts exactly `MAX_HOLD` cycles before the dead cycle.
- **Reset:** `reset` high at edge k gives all outputs at their reset values after edge k. With `req`≠0 on the first edge after `reset` falls, the first grant appears after that edge and goes to the lowest set bit (`ptr`=0).

## Test plan
- **Reset:** `reset`=1 for 2 cycles with `req`=8'hFF → `grant`=8'h00, `busy`=0, `grant_id`=0 during reset. After release, `grant`=8'h01 one edge later.
- **Single request:** `req`=8'h04 → `grant`=8'h04, `grant_id`=2, `busy`=1 after one edge. Then `req`=8'h00 → `grant`=8'h00 next edge, and `ptr` becomes 3.
- **Full contention, `MAX_HOLD`=4:** `req`=8'hFF held → the `grant` sequence is 01×4, 00, 02×4, 00, … 80×4, 00, 01×4. Check the one-hot invariant every cycle.
- **Wrap-around:** serve requester 6 alone, then release it so `ptr`=7. Apply `req`=8'h41 → `grant`=8'h01 first. After preemption or release, `grant`=8'h40.
- **Uncontended hold:** `req`=8'h08 held for 20 cycles → `grant`=8'h08 on every cycle, with no dead cycle. Then raise bit 1 → within one edge `grant`=8'h00, then `grant`=8'h02.
- **Reset mid-grant:** while `grant`=8'h10, assert `reset` for one cycle → `grant`=8'h00 and `busy`=0 after that edge. Next grant goes to the lowest pending index.
